lbp_frame_engine: RTL and testbench

Parametrised Local Binary Pattern engine. It reads a 2^ROW_BITS × 2^COL_BITS grey image from an external grey memory through a req/ready handshake and writes one LBP code per pixel to the result memory. The block generalises the existing fixed 128×128, always-ready LBP core: image size and pixel width are parametrised, the grey-side handshake is honoured, border pixels are written explicitly, and a thresholded compare mode is added. It sits between the grey-image ROM model and the LBP result RAM in the image-processing testbench.

---
 rtl/lbp_frame_engine.sv | 168 ++++++++++++++++
 tb/tb_lbp_frame_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_frame_engine.sv
// lbp_frame_engine
//   Local Binary Pattern engine over a 2^ROW_BITS x 2^COL_BITS grey image.
//   Walks the pixels in raster order. For each interior pixel it fetches the
//   centre and its eight neighbours through a req/ready read port. It then
//   writes one 8-bit LBP code per pixel. Border pixels are written as code 0
//   without any fetch.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start                 one-cycle pulse, accepted in IDLE or DONE
//   mode, thr             compare mode (0 std, 1 thresholded) and threshold,
//                         both latched on an accepted start
//   gray_req/gray_addr    read request and {row, col} address, held until ready
//   gray_ready/gray_data  read data strobe and pixel
//   lbp_valid/addr/data   one-cycle result write strobe, {row, col}, LBP code
//   busy, finish          frame in progress / frame complete (level)
module lbp_frame_engine #(
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 7,
    parameter int DW       = 8,
    localparam int AW      = ROW_BITS + COL_BITS
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          mode,
    input  logic [DW-1:0] thr,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic          gray_ready,
    input  logic [DW-1:0] gray_data,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data,
    output logic          busy,
    output logic          finish
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state;
    logic [AW-1:0]       p;
    logic [3:0]          k;
    logic [DW-1:0]       centre;
    logic [7:0]          code;
    logic                mode_r;
    logic [DW-1:0]       thr_r;

    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic                is_border;
    logic [3:0]          nidx;
    logic [ROW_BITS-1:0] nrow;
    logic [COL_BITS-1:0] ncol;
    logic [DW:0]         limit;
    logic                hit;
    logic [3:0]          kbit;

    assign row = p[AW-1:COL_BITS];
    assign col = p[COL_BITS-1:0];
    assign is_border = (row == '0) || (row == '1) || (col == '0) || (col == '1);

    // Address of the next fetch (index k+1): neighbours g0..g7 in raster order.
    assign nidx = k + 4'd1;
    always_comb begin
        nrow = row;
        ncol = col;
        case (nidx)
            4'd1: begin nrow = row - ROW_BITS'(1); ncol = col - COL_BITS'(1); end
            4'd2: begin nrow = row - ROW_BITS'(1);                            end
            4'd3: begin nrow = row - ROW_BITS'(1); ncol = col + COL_BITS'(1); end
            4'd4: begin                            ncol = col - COL_BITS'(1); end
            4'd5: begin                            ncol = col + COL_BITS'(1); end
            4'd6: begin nrow = row + ROW_BITS'(1); ncol = col - COL_BITS'(1); end
            4'd7: begin nrow = row + ROW_BITS'(1);                            end
            4'd8: begin nrow = row + ROW_BITS'(1); ncol = col + COL_BITS'(1); end
            default: ;
        endcase
    end

    // Compare at DW+1 bits so centre + thr never saturates.
    assign limit = mode_r ? ({1'b0, centre} + {1'b0, thr_r}) : {1'b0, centre};
    assign hit   = ({1'b0, gray_data} >= limit);
    assign kbit  = k - 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            p         <= '0;
            k         <= '0;
            centre    <= '0;
            code      <= '0;
            mode_r    <= 1'b0;
            thr_r     <= '0;
            gray_req  <= 1'b0;
            gray_addr <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_r <= mode;
                        thr_r  <= thr;
                        p      <= '0;
                        busy   <= 1'b1;
                        finish <= 1'b0;
                        state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (is_border) begin
                        lbp_valid <= 1'b1;
                        lbp_addr  <= p;
                        lbp_data  <= '0;
                        state     <= S_WRITE;
                    end else begin
                        gray_req  <= 1'b1;
                        gray_addr <= p;
                        k         <= '0;
                        code      <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (gray_ready) begin
                        if (k == 4'd0) begin
                            centre <= gray_data;
                        end else begin
                            code[kbit[2:0]] <= hit;
                        end
                        if (k == 4'd8) begin
                            // Last neighbour lands directly in the output code.
                            gray_req  <= 1'b0;
                            lbp_valid <= 1'b1;
                            lbp_addr  <= p;
                            lbp_data  <= {hit, code[6:0]};
                            state     <= S_WRITE;
                        end else begin
                            k         <= nidx;
                            gray_addr <= {nrow, ncol};
                        end
                    end
                end
                S_WRITE: begin
                    lbp_valid <= 1'b0;
                    if (p == '1) begin
                        busy   <= 1'b0;
                        finish <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        p     <= p + AW'(1);
                        state <= S_SCAN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_frame_engine.sv
// Bench for lbp_frame_engine on a 4x4 image. Stimulus pushes expected
// {addr, code} writes into a queue; a monitor pops and compares on lbp_valid.
module tb_lbp_frame_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       mode;
    logic [7:0] thr;
    logic       gray_req;
    logic [3:0] gray_addr;
    logic       gray_ready;
    logic [7:0] gray_data;
    logic       lbp_valid;
    logic [3:0] lbp_addr;
    logic [7:0] lbp_data;
    logic       busy;
    logic       finish;

    int checks = 0;
    int errors = 0;

    logic [7:0] img [16];
    bit         rand_ready = 1'b0;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } exp_t;
    exp_t q[$];

    lbp_frame_engine #(.COL_BITS(2), .ROW_BITS(2), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .thr(thr),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready),
        .gray_data(gray_data), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    assign gray_data = img[gray_addr];

    initial begin
        gray_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            gray_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on each write, plus read-port hold check.
    initial begin
        logic       prev_ok, prev_req, prev_rdy;
        logic [3:0] prev_addr;
        exp_t       e;
        prev_ok = 1'b0; prev_req = 1'b0; prev_rdy = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset_n && lbp_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%02h expected no write", lbp_addr, lbp_data);
                end else begin
                    e = q.pop_front();
                    if (lbp_addr !== e.a || lbp_data !== e.d) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%02h expected addr=%0d data=%02h",
                                 lbp_addr, lbp_data, e.a, e.d);
                    end
                end
            end
            if (reset_n && prev_ok && prev_req && !prev_rdy) begin
                checks++;
                if (gray_req !== 1'b1 || gray_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL req_hold got req=%b addr=%0d expected req=1 addr=%0d",
                             gray_req, gray_addr, prev_addr);
                end
            end
            prev_ok   = reset_n;
            prev_req  = gray_req;
            prev_rdy  = gray_ready;
            prev_addr = gray_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push_frame(input logic [7:0] c5, c6, c9, c10);
        exp_t e;
        for (int p = 0; p < 16; p++) begin
            e.a = 4'(p);
            case (p)
                5:       e.d = c5;
                6:       e.d = c6;
                9:       e.d = c9;
                10:      e.d = c10;
                default: e.d = 8'h00;
            endcase
            q.push_back(e);
        end
    endtask

    task automatic load_linear();
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
    endtask

    task automatic load_const(input logic [7:0] v);
        for (int i = 0; i < 16; i++) img[i] = v;
    endtask

    // All 100 except pixel 5 = 50 and pixel 10 = 200.
    task automatic load_spot();
        for (int i = 0; i < 16; i++) img[i] = 8'd100;
        img[5]  = 8'd50;
        img[10] = 8'd200;
    endtask

    task automatic run_frame(input string name, input logic m, input logic [7:0] t,
                             input logic [7:0] c5, c6, c9, c10,
                             input bit check_len, input bit pulse_mid);
        int cnt;
        push_frame(c5, c6, c9, c10);
        @(negedge clk);
        mode = m; thr = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        check({name, "_finish_drop"}, 32'(finish), 32'd0);
        cnt = 0;
        while (!finish && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (pulse_mid && cnt == 20) begin
                start = 1'b1; mode = ~m; thr = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        if (!finish) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout got no finish after %0d cycles expected finish", name, cnt);
        end
        if (check_len) check({name, "_cycles"}, 32'(cnt), 32'd68);
        check({name, "_busy_fall"}, 32'(busy), 32'd0);
        check({name, "_writes_left"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; thr = '0;
        load_linear();
        #1;
        check("rst_gray_req", 32'(gray_req), 32'd0);
        check("rst_gray_addr", 32'(gray_addr), 32'd0);
        check("rst_lbp_valid", 32'(lbp_valid), 32'd0);
        check("rst_lbp_addr", 32'(lbp_addr), 32'd0);
        check("rst_lbp_data", 32'(lbp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_frame("lin_m0", 1'b0, 8'd0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 1'b1, 1'b0);
        run_frame("lin_m1_t4", 1'b1, 8'd4, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b1, 1'b0);
        run_frame("lin_start_busy", 1'b0, 8'd0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 1'b1, 1'b1);

        load_const(8'd255);
        run_frame("ff_m1_t1", 1'b1, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        run_frame("ff_m0_eq", 1'b0, 8'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);

        load_spot();
        run_frame("spot_m0", 1'b0, 8'd0, 8'hFF, 8'hF7, 8'hFD, 8'h00, 1'b1, 1'b0);
        run_frame("spot_m1_t60", 1'b1, 8'd60, 8'h80, 8'h40, 8'h10, 8'h00, 1'b1, 1'b0);

        rand_ready = 1'b1;
        run_frame("spot_rand", 1'b0, 8'd0, 8'hFF, 8'hF7, 8'hFD, 8'h00, 1'b0, 1'b0);
        load_linear();
        run_frame("lin_rand", 1'b1, 8'd4, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0, 1'b0);
        rand_ready = 1'b0;

        // Reset in the middle of a frame, once pixel 6 has been written.
        push_frame(8'hF0, 8'hF0, 8'hF0, 8'hF0);
        @(negedge clk);
        mode = 1'b0; thr = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (q.size() > 9 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_reached", 32'(q.size() <= 9), 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_outputs",
              {19'd0, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, busy, finish}, 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_frame("after_rst", 1'b0, 8'd0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
